// File: rtl/pcpi_initiator.sv
// pcpi_initiator: takes one command (instruction + two operands) over a
// valid/ready interface, drives it onto a PCPI bus, waits for the coprocessor
// to complete or for the claim timeout, then returns result / write flag /
// timeout status over a valid/ready response interface.
//
// Ports:
//   clkIn, rstLowIn             clock (rising edge), async active-low reset
//   cmdValidIn/cmdReadyOut      command handshake
//   cmdInstIn/Rs1In/Rs2In       command payload
//   pcpiValidOut, pcpiInstOut,
//   pcpiRs1Out, pcpiRs2Out      PCPI request towards the coprocessor
//   pcpiWrIn, pcpiRdIn,
//   pcpiWaitIn, pcpiReadyIn     PCPI response from the coprocessor
//   rspValidOut/rspReadyIn      response handshake
//   rspDataOut, rspWrOut,
//   rspTimeoutOut               response payload
//   busyOut                     high whenever not IDLE
module pcpi_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic        clkIn,
    input  logic        rstLowIn,
    input  logic        cmdValidIn,
    output logic        cmdReadyOut,
    input  logic [31:0] cmdInstIn,
    input  logic [31:0] cmdRs1In,
    input  logic [31:0] cmdRs2In,
    output logic        pcpiValidOut,
    output logic [31:0] pcpiInstOut,
    output logic [31:0] pcpiRs1Out,
    output logic [31:0] pcpiRs2Out,
    input  logic        pcpiWrIn,
    input  logic [31:0] pcpiRdIn,
    input  logic        pcpiWaitIn,
    input  logic        pcpiReadyIn,
    output logic        rspValidOut,
    input  logic        rspReadyIn,
    output logic [31:0] rspDataOut,
    output logic        rspWrOut,
    output logic        rspTimeoutOut,
    output logic        busyOut
);

    localparam int unsigned TO_W  = 8;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned XLEN  = 32;

    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
    logic              r_pcpi_valid, w_pcpi_valid_nxt;
    logic [XLEN-1:0]   r_inst, w_inst_nxt;
    logic [XLEN-1:0]   r_rs1, w_rs1_nxt;
    logic [XLEN-1:0]   r_rs2, w_rs2_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [XLEN-1:0]   r_rsp_data, w_rsp_data_nxt;
    logic              r_rsp_wr, w_rsp_wr_nxt;
    logic              r_rsp_to, w_rsp_to_nxt;
    logic              r_cmd_ready, w_cmd_ready_nxt;
    logic              r_busy, w_busy_nxt;

    // State and output registers; reset parks in GAP so the responder sees
    // valid low long enough to clear its edge detectors.
    always_ff @(posedge clkIn or negedge rstLowIn) begin
        if (!rstLowIn) begin
            r_state      <= GAP;
            r_to_cnt     <= '0;
            r_gap_cnt    <= GAP_LOAD;
            r_pcpi_valid <= 1'b0;
            r_inst       <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_wr     <= 1'b0;
            r_rsp_to     <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_pcpi_valid <= w_pcpi_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_rs1        <= w_rs1_nxt;
            r_rs2        <= w_rs2_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_rsp_wr     <= w_rsp_wr_nxt;
            r_rsp_to     <= w_rsp_to_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_to_cnt_nxt     = r_to_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_pcpi_valid_nxt = r_pcpi_valid;
        w_inst_nxt       = r_inst;
        w_rs1_nxt        = r_rs1;
        w_rs2_nxt        = r_rs2;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_data_nxt   = r_rsp_data;
        w_rsp_wr_nxt     = r_rsp_wr;
        w_rsp_to_nxt     = r_rsp_to;

        unique case (r_state)
            IDLE: begin
                if (cmdValidIn && r_cmd_ready) begin
                    w_inst_nxt       = cmdInstIn;
                    w_rs1_nxt        = cmdRs1In;
                    w_rs2_nxt        = cmdRs2In;
                    w_pcpi_valid_nxt = 1'b1;
                    w_to_cnt_nxt     = TO_LOAD;
                    w_state_nxt      = ISSUE;
                end
            end

            // Ready beats wait beats timeout; wait keeps the claim alive forever.
            ISSUE: begin
                if (pcpiReadyIn) begin
                    w_rsp_data_nxt   = pcpiRdIn;
                    w_rsp_wr_nxt     = pcpiWrIn;
                    w_rsp_to_nxt     = 1'b0;
                    w_pcpi_valid_nxt = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_state_nxt      = RESP;
                end else if (pcpiWaitIn) begin
                    w_to_cnt_nxt = TO_LOAD;
                end else if (r_to_cnt == TO_W'(1)) begin
                    w_rsp_data_nxt   = '0;
                    w_rsp_wr_nxt     = 1'b0;
                    w_rsp_to_nxt     = 1'b1;
                    w_pcpi_valid_nxt = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_state_nxt      = RESP;
                end else begin
                    w_to_cnt_nxt = r_to_cnt - TO_W'(1);
                end
            end

            // Response held; PCPI inputs are deliberately not looked at here.
            RESP: begin
                if (rspReadyIn) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_gap_cnt_nxt   = GAP_LOAD;
                    w_state_nxt     = GAP;
                end
            end

            // Enforced quiet period on pcpiValidOut between requests.
            GAP: begin
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                w_state_nxt = GAP;
            end
        endcase
    end

    // Ready/busy registered from the upcoming state so they track the FSM.
    assign w_cmd_ready_nxt = (w_state_nxt == IDLE);
    assign w_busy_nxt      = (w_state_nxt != IDLE);

    assign cmdReadyOut   = r_cmd_ready;
    assign busyOut       = r_busy;
    assign pcpiValidOut  = r_pcpi_valid;
    assign pcpiInstOut   = r_inst;
    assign pcpiRs1Out    = r_rs1;
    assign pcpiRs2Out    = r_rs2;
    assign rspValidOut   = r_rsp_valid;
    assign rspDataOut    = r_rsp_data;
    assign rspWrOut      = r_rsp_wr;
    assign rspTimeoutOut = r_rsp_to;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Bench for pcpi_initiator: behavioural FPU responder on the PCPI side,
// expected responses queued when commands are issued, compared on output.
module tb_pcpi_initiator;

    localparam int unsigned TO  = 16;
    localparam int unsigned GAP = 2;

    localparam logic [31:0] FADD = 32'h0020_8053;
    localparam logic [31:0] FMUL = 32'h1020_8053;
    localparam logic [31:0] F1   = 32'h3F80_0000;
    localparam logic [31:0] F2   = 32'h4000_0000;
    localparam logic [31:0] F3   = 32'h4040_0000;
    localparam logic [31:0] F6   = 32'h40C0_0000;

    logic        clkIn = 1'b0;
    logic        rstLowIn;
    logic        cmdValidIn;
    logic        cmdReadyOut;
    logic [31:0] cmdInstIn, cmdRs1In, cmdRs2In;
    logic        pcpiValidOut;
    logic [31:0] pcpiInstOut, pcpiRs1Out, pcpiRs2Out;
    logic        pcpiWrIn;
    logic [31:0] pcpiRdIn;
    logic        pcpiWaitIn, pcpiReadyIn;
    logic        rspValidOut, rspReadyIn;
    logic [31:0] rspDataOut;
    logic        rspWrOut, rspTimeoutOut, busyOut;

    pcpi_initiator #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clkIn(clkIn), .rstLowIn(rstLowIn),
        .cmdValidIn(cmdValidIn), .cmdReadyOut(cmdReadyOut),
        .cmdInstIn(cmdInstIn), .cmdRs1In(cmdRs1In), .cmdRs2In(cmdRs2In),
        .pcpiValidOut(pcpiValidOut), .pcpiInstOut(pcpiInstOut),
        .pcpiRs1Out(pcpiRs1Out), .pcpiRs2Out(pcpiRs2Out),
        .pcpiWrIn(pcpiWrIn), .pcpiRdIn(pcpiRdIn),
        .pcpiWaitIn(pcpiWaitIn), .pcpiReadyIn(pcpiReadyIn),
        .rspValidOut(rspValidOut), .rspReadyIn(rspReadyIn),
        .rspDataOut(rspDataOut), .rspWrOut(rspWrOut),
        .rspTimeoutOut(rspTimeoutOut), .busyOut(busyOut)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   low_run  = 0;
    int   last_gap = 0;

    // Length of the most recent low stretch of pcpiValidOut before a request.
    always @(negedge clkIn) begin
        if (!rstLowIn) begin
            low_run = 0;
        end else if (pcpiValidOut) begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clkIn);
    endtask

    // Tiny FPU: only the operations this bench issues.
    function automatic logic [31:0] fpu_result(input logic [31:0] inst, input logic [31:0] a,
                                               input logic [31:0] b);
        if (inst == FADD && a == F1 && b == F2) return F3;
        if (inst == FMUL && a == F2 && b == F3) return F6;
        return 32'h0;
    endfunction

    task automatic issue_cmd(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] ed, input logic ew, input logic et);
        int   n = 0;
        rsp_t e;
        while (!cmdReadyOut && n < 50) begin tick(); n++; end
        if (!cmdReadyOut) check("cmd_ready_wait", 32'(cmdReadyOut), 32'd1);
        cmdValidIn = 1'b1;
        cmdInstIn  = inst;
        cmdRs1In   = rs1;
        cmdRs2In   = rs2;
        e.data = ed; e.wr = ew; e.to = et;
        sb.push_back(e);
        tick();
        cmdValidIn = 1'b0;
        check("pcpi_valid_after_accept", 32'(pcpiValidOut), 32'd1);
        check("pcpi_inst", pcpiInstOut, inst);
        check("pcpi_rs1", pcpiRs1Out, rs1);
        check("pcpi_rs2", pcpiRs2Out, rs2);
        check("cmd_ready_in_issue", 32'(cmdReadyOut), 32'd0);
    endtask

    // Waits nwait cycles with wait high, then pulses ready with the FPU result.
    task automatic respond(input int nwait);
        for (int i = 0; i < nwait; i++) begin pcpiWaitIn = 1'b1; tick(); end
        pcpiWaitIn  = 1'b0;
        pcpiReadyIn = 1'b1;
        pcpiWrIn    = 1'b1;
        pcpiRdIn    = fpu_result(pcpiInstOut, pcpiRs1Out, pcpiRs2Out);
        tick();
        pcpiReadyIn = 1'b0;
        pcpiWrIn    = 1'b0;
        pcpiRdIn    = 32'h0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rspValidOut && cyc < 200) begin tick(); cyc++; end
        if (!rspValidOut) check("rsp_valid_wait", 32'(rspValidOut), 32'd1);
    endtask

    // Compare against the scoreboard, hold under backpressure, then handshake.
    task automatic take_rsp(input int hold, input bit poke);
        rsp_t e;
        logic [31:0] d0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("rsp_data", rspDataOut, e.data);
        check("rsp_wr", 32'(rspWrOut), 32'(e.wr));
        check("rsp_timeout", 32'(rspTimeoutOut), 32'(e.to));
        d0 = rspDataOut;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                pcpiReadyIn = 1'b1; pcpiWrIn = 1'b0; pcpiRdIn = 32'hDEAD_BEEF;
            end else begin
                pcpiReadyIn = 1'b0; pcpiWrIn = 1'b0; pcpiRdIn = 32'h0;
            end
            tick();
            check("rsp_valid_held", 32'(rspValidOut), 32'd1);
            check("rsp_data_stable", rspDataOut, d0);
            check("rsp_wr_stable", 32'(rspWrOut), 32'(e.wr));
            check("cmd_ready_in_resp", 32'(cmdReadyOut), 32'd0);
        end
        pcpiReadyIn = 1'b0; pcpiWrIn = 1'b0; pcpiRdIn = 32'h0;
        rspReadyIn = 1'b1;
        tick();
        rspReadyIn = 1'b0;
        check("rsp_valid_cleared", 32'(rspValidOut), 32'd0);
    endtask

    task automatic count_ready_after_release();
        int n = 0;
        rstLowIn = 1'b1;
        while (!cmdReadyOut && n < 50) begin tick(); n++; end
        check("ready_after_reset_cycles", 32'(n), 32'(GAP));
    endtask

    // Asynchronous reset between clock edges, outputs checked before any edge.
    task automatic reset_pulse(input string tag);
        #2 rstLowIn = 1'b0;
        #1;
        check({tag, "_pcpi_valid"}, 32'(pcpiValidOut), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rspValidOut), 32'd0);
        check({tag, "_busy"}, 32'(busyOut), 32'd1);
        sb.delete();
        pcpiWaitIn = 1'b0; pcpiReadyIn = 1'b0; pcpiWrIn = 1'b0; pcpiRdIn = 32'h0;
        tick();
        count_ready_after_release();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int cyc;
        rstLowIn = 1'b0;
        cmdValidIn = 1'b0; cmdInstIn = 32'h0; cmdRs1In = 32'h0; cmdRs2In = 32'h0;
        pcpiWrIn = 1'b0; pcpiRdIn = 32'h0; pcpiWaitIn = 1'b0; pcpiReadyIn = 1'b0;
        rspReadyIn = 1'b0;

        // Reset values
        #12;
        check("reset_pcpi_valid", 32'(pcpiValidOut), 32'd0);
        check("reset_rsp_valid", 32'(rspValidOut), 32'd0);
        check("reset_rsp_wr", 32'(rspWrOut), 32'd0);
        check("reset_rsp_timeout", 32'(rspTimeoutOut), 32'd0);
        check("reset_cmd_ready", 32'(cmdReadyOut), 32'd0);
        check("reset_busy", 32'(busyOut), 32'd1);
        check("reset_pcpi_inst", pcpiInstOut, 32'h0);
        check("reset_rsp_data", rspDataOut, 32'h0);
        tick();
        count_ready_after_release();
        check("idle_busy", 32'(busyOut), 32'd0);

        // fadd.s through the FPU responder
        issue_cmd(FADD, F1, F2, F3, 1'b1, 1'b0);
        respond(2);
        wait_rsp(cyc);
        take_rsp(0, 1'b0);

        // Timeout with an idle responder
        issue_cmd(FADD, F1, F2, 32'h0, 1'b0, 1'b1);
        wait_rsp(cyc);
        check("timeout_latency", 32'(cyc), 32'(TO));
        take_rsp(0, 1'b0);

        // Wait held for 40 cycles, then ready
        issue_cmd(32'h0000_0053, 32'h1, 32'h2, 32'h1234_5678, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin pcpiWaitIn = 1'b1; tick(); end
        check("no_rsp_during_wait", 32'(rspValidOut), 32'd0);
        pcpiWaitIn = 1'b0; pcpiReadyIn = 1'b1; pcpiWrIn = 1'b1; pcpiRdIn = 32'h1234_5678;
        tick();
        pcpiReadyIn = 1'b0; pcpiWrIn = 1'b0; pcpiRdIn = 32'h0;
        wait_rsp(cyc);
        take_rsp(0, 1'b0);

        // Ready arriving in the same cycle the counter reaches 1
        issue_cmd(32'h0000_0053, 32'h3, 32'h4, 32'hCAFE_F00D, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin pcpiWaitIn = 1'b1; tick(); end
        pcpiWaitIn = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("no_early_timeout", 32'(rspValidOut), 32'd0);
        pcpiReadyIn = 1'b1; pcpiWrIn = 1'b1; pcpiRdIn = 32'hCAFE_F00D;
        tick();
        pcpiReadyIn = 1'b0; pcpiWrIn = 1'b0; pcpiRdIn = 32'h0;
        check("ready_wins_rsp_valid", 32'(rspValidOut), 32'd1);
        take_rsp(0, 1'b0);

        // Backpressure, second command held, ready in first ISSUE cycle
        issue_cmd(FADD, F1, F2, F3, 1'b1, 1'b0);
        begin
            rsp_t e2;
            cmdValidIn = 1'b1; cmdInstIn = FMUL; cmdRs1In = F2; cmdRs2In = F3;
            e2.data = F6; e2.wr = 1'b1; e2.to = 1'b0;
            sb.push_back(e2);
        end
        pcpiReadyIn = 1'b1; pcpiWrIn = 1'b1; pcpiRdIn = F3;
        tick();
        pcpiReadyIn = 1'b0; pcpiWrIn = 1'b0; pcpiRdIn = 32'h0;
        check("first_cycle_ready_rsp", 32'(rspValidOut), 32'd1);
        take_rsp(5, 1'b1);
        check("cmd_ready_in_gap", 32'(cmdReadyOut), 32'd0);
        cyc = 0;
        while (!pcpiValidOut && cyc < 50) begin tick(); cyc++; end
        check("second_request_issued", 32'(pcpiValidOut), 32'd1);
        cmdValidIn = 1'b0;
        check("gap_low_cycles_ok", 32'(last_gap >= int'(GAP + 1)), 32'd1);
        check("second_pcpi_inst", pcpiInstOut, FMUL);
        respond(1);
        wait_rsp(cyc);
        take_rsp(0, 1'b0);

        // Reset while wait is held in ISSUE
        issue_cmd(FADD, F1, F2, F3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin pcpiWaitIn = 1'b1; tick(); end
        reset_pulse("rst_issue");

        // Reset while a response is pending
        issue_cmd(FADD, F1, F2, F3, 1'b1, 1'b0);
        respond(0);
        check("pre_reset_rsp_valid", 32'(rspValidOut), 32'd1);
        reset_pulse("rst_resp");

        // Normal operation after reset
        issue_cmd(FADD, F1, F2, F3, 1'b1, 1'b0);
        respond(1);
        wait_rsp(cyc);
        take_rsp(0, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
